// File: rtl/m1_refresh_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// m1_refresh_sequencer_pkg
//   Shared definitions for the Z80 M1 opcode-fetch sequencer:
//   - t-state encoding (3 bits), also driven out on the t_state debug port
//   - default R refresh mask (low 7 bits of R increment)
//   - helper to build the increment mask for a given number of refresh bits
// -----------------------------------------------------------------------------
package m1_refresh_sequencer_pkg;

    typedef logic [2:0] t_state_t;

    localparam t_state_t ST_IDLE = 3'd0;
    localparam t_state_t ST_T1   = 3'd1;
    localparam t_state_t ST_T2   = 3'd2;
    localparam t_state_t ST_TW   = 3'd3;
    localparam t_state_t ST_T3   = 3'd4;
    localparam t_state_t ST_T4   = 3'd5;

    // Ones in the low 'bits' positions of an 8-bit R value; saturates at 8.
    function automatic logic [7:0] rfsh_mask(input int bits);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < bits) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Standard Z80: bit 7 of R is never touched by the refresh counter.
    localparam logic [7:0] R_RFSH_MASK = rfsh_mask(7);

endpackage

// File: rtl/m1_refresh_sequencer_r_next_calc.sv
// -----------------------------------------------------------------------------
// m1_refresh_sequencer_r_next_calc
//   Combinational next-value for the R register.
//   An explicit LD R,A write takes priority; otherwise the low RFSH_BITS of R
//   increment (wrapping) and the upper bits are carried through unchanged.
// Ports:
//   reg_r      in   8  current R value
//   ld_r       in   1  explicit R write request
//   ld_r_data  in   8  data for explicit R write
//   r_in       out  8  value presented to the R register
// -----------------------------------------------------------------------------
module m1_refresh_sequencer_r_next_calc
    import m1_refresh_sequencer_pkg::*;
#(
    parameter int RFSH_BITS = 7
) (
    input  logic [7:0] reg_r,
    input  logic       ld_r,
    input  logic [7:0] ld_r_data,
    output logic [7:0] r_in
);

    localparam logic [7:0] INC_MASK = rfsh_mask(RFSH_BITS);

    logic [7:0] r_plus_one;
    logic [7:0] r_incremented;

    assign r_plus_one = reg_r + 8'd1;

    // Carry out of the masked field is discarded by masking the sum, which
    // gives the mod 2^RFSH_BITS wrap while keeping the upper bits of R.
    assign r_incremented = (r_plus_one & INC_MASK) | (reg_r & ~INC_MASK);

    assign r_in = ld_r ? ld_r_data : r_incremented;

endmodule

// File: rtl/m1_refresh_sequencer.sv
// -----------------------------------------------------------------------------
// m1_refresh_sequencer
//   Sequences the Z80 M1 opcode-fetch cycle: T1, T2, optional TW wait states,
//   T3, T4. During T3/T4 it drives the refresh address {I,R} captured on entry
//   to T3, and during T3 it writes the incremented R back. Explicit LD R,A
//   writes pass straight through and win over the T3 increment.
// Ports:
//   clk           in   1   system clock
//   reset         in   1   asynchronous active-high reset
//   fetch_start   in   1   request an M1 cycle (sampled in IDLE and T4)
//   wait_n        in   1   active-low wait (sampled in T2/TW)
//   reg_i         in   8   current I register
//   reg_r         in   8   current R register
//   ld_r          in   1   explicit R write request
//   ld_r_data     in   8   explicit R write data
//   r_wr          out  1   R write strobe
//   r_in          out  8   R write data
//   m1_active     out  1   high in T1/T2/TW
//   rfsh_active   out  1   high in T3/T4
//   rfsh_addr     out  16  refresh address {I,R}
//   opcode_latch  out  1   pulse in T3
//   fetch_done    out  1   pulse in T4
//   t_state       out  3   current state encoding (debug)
// -----------------------------------------------------------------------------
module m1_refresh_sequencer
    import m1_refresh_sequencer_pkg::*;
#(
    parameter int RFSH_BITS   = 7,
    parameter bit WAIT_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        wait_n,
    input  logic [7:0]  reg_i,
    input  logic [7:0]  reg_r,
    input  logic        ld_r,
    input  logic [7:0]  ld_r_data,
    output logic        r_wr,
    output logic [7:0]  r_in,
    output logic        m1_active,
    output logic        rfsh_active,
    output logic [15:0] rfsh_addr,
    output logic        opcode_latch,
    output logic        fetch_done,
    output logic [2:0]  t_state
);

    t_state_t    state_q;
    t_state_t    state_d;
    logic [15:0] rfsh_addr_q;
    logic        enter_t3;
    logic        wait_req;

    assign wait_req = WAIT_ENABLE && !wait_n;

    // Next-state logic. fetch_start is only looked at in IDLE and T4, so a
    // request raised mid-cycle is simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fetch_start) state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = wait_req ? ST_TW : ST_T3;
            ST_TW:   state_d = wait_req ? ST_TW : ST_T3;
            ST_T3:   state_d = ST_T4;
            ST_T4:   state_d = fetch_start ? ST_T1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_t3 = ((state_q == ST_T2) || (state_q == ST_TW)) && (state_d == ST_T3);

    // rfsh_addr is taken before the T3 increment lands, so refresh always
    // uses the pre-increment R and is unaffected by a competing LD R,A.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rfsh_addr_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (enter_t3) rfsh_addr_q <= {reg_i, reg_r};
        end
    end

    m1_refresh_sequencer_r_next_calc #(
        .RFSH_BITS (RFSH_BITS)
    ) u_r_next_calc (
        .reg_r     (reg_r),
        .ld_r      (ld_r),
        .ld_r_data (ld_r_data),
        .r_in      (r_in)
    );

    // Status outputs decode registered state only, so they carry no input
    // glitches. r_wr is the one output that also follows ld_r directly.
    assign r_wr         = ld_r || (state_q == ST_T3);
    assign m1_active    = (state_q == ST_T1) || (state_q == ST_T2) || (state_q == ST_TW);
    assign rfsh_active  = (state_q == ST_T3) || (state_q == ST_T4);
    assign opcode_latch = (state_q == ST_T3);
    assign fetch_done   = (state_q == ST_T4);
    assign rfsh_addr    = rfsh_addr_q;
    assign t_state      = state_q;

endmodule

// File: tb/tb_m1_refresh_sequencer.sv
module tb_m1_refresh_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_TW   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start;
  logic        wait_n;
  logic [7:0]  reg_i;
  logic [7:0]  reg_r = 8'h00;
  logic        ld_r;
  logic [7:0]  ld_r_data;
  logic        r_wr;
  logic [7:0]  r_in;
  logic        m1_active;
  logic        rfsh_active;
  logic [15:0] rfsh_addr;
  logic        opcode_latch;
  logic        fetch_done;
  logic [2:0]  t_state;

  int n_tests = 0;
  int n_fail  = 0;

  // R register model: a bench-side preload, otherwise the DUT write port.
  logic       r_set = 1'b0;
  logic [7:0] r_set_val = 8'h00;

  // clock/reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (r_set) reg_r <= r_set_val;
    else if (r_wr) reg_r <= r_in;
  end

  m1_refresh_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_start  (fetch_start),
    .wait_n       (wait_n),
    .reg_i        (reg_i),
    .reg_r        (reg_r),
    .ld_r         (ld_r),
    .ld_r_data    (ld_r_data),
    .r_wr         (r_wr),
    .r_in         (r_in),
    .m1_active    (m1_active),
    .rfsh_active  (rfsh_active),
    .rfsh_addr    (rfsh_addr),
    .opcode_latch (opcode_latch),
    .fetch_done   (fetch_done),
    .t_state      (t_state)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_r(input logic [7:0] v);
    r_set_val = v;
    r_set = 1'b1;
    step();
    r_set = 1'b0;
  endtask

  // checker
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    fetch_start = 1'b0;
    wait_n = 1'b1;
    reg_i = 8'h00;
    ld_r = 1'b0;
    ld_r_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    check("rst_state", 16'(t_state), 16'(S_IDLE));
    check("rst_addr", rfsh_addr, 16'h0000);
    check("rst_flags", {11'd0, m1_active, rfsh_active, opcode_latch, fetch_done, r_wr}, 16'h0000);
    reset = 1'b0;

    // basic fetch, no waits
    reg_i = 8'h12;
    set_r(8'h3C);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check("b_t1_state", 16'(t_state), 16'(S_T1));
    check("b_t1_m1", 16'(m1_active), 16'd1);
    check("b_t1_rwr", 16'(r_wr), 16'd0);
    step();
    check("b_t2_state", 16'(t_state), 16'(S_T2));
    step();
    check("b_t3_state", 16'(t_state), 16'(S_T3));
    check("b_t3_addr", rfsh_addr, 16'h123C);
    check("b_t3_rwr", 16'(r_wr), 16'd1);
    check("b_t3_rin", 16'(r_in), 16'h003D);
    check("b_t3_flags", {13'd0, m1_active, rfsh_active, opcode_latch}, 16'h0003);
    step();
    check("b_t4_state", 16'(t_state), 16'(S_T4));
    check("b_t4_done", 16'(fetch_done), 16'd1);
    check("b_t4_rwr", 16'(r_wr), 16'd0);
    check("b_t4_addr", rfsh_addr, 16'h123C);
    check("b_t4_r", 16'(reg_r), 16'h003D);
    step();
    check("b_idle", 16'(t_state), 16'(S_IDLE));
    check("b_idle_done", 16'(fetch_done), 16'd0);

    // wrap of the low 7 bits, 7F -> 00
    set_r(8'h7F);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    step();
    check("w7f_rin", 16'(r_in), 16'h0000);
    step();
    check("w7f_r", 16'(reg_r), 16'h0000);
    step();

    // bit 7 preserved, FF -> 80
    set_r(8'hFF);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    step();
    check("wff_rin", 16'(r_in), 16'h0080);
    check("wff_addr", rfsh_addr, 16'h12FF);
    step();
    check("wff_r", 16'(reg_r), 16'h0080);
    step();

    // two wait states; fetch_start raised during TW must be ignored
    set_r(8'h40);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    wait_n = 1'b0;
    check("ws_c1", 16'(t_state), 16'(S_T1));
    step();
    check("ws_c2", 16'(t_state), 16'(S_T2));
    step();
    check("ws_c3", 16'(t_state), 16'(S_TW));
    check("ws_c3_m1", 16'(m1_active), 16'd1);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check("ws_c4", 16'(t_state), 16'(S_TW));
    wait_n = 1'b1;
    step();
    check("ws_c5", 16'(t_state), 16'(S_T3));
    check("ws_c5_latch", 16'(opcode_latch), 16'd1);
    check("ws_c5_addr", rfsh_addr, 16'h1240);
    step();
    check("ws_c6", 16'(t_state), 16'(S_T4));
    check("ws_c6_addr", rfsh_addr, 16'h1240);
    check("ws_c6_r", 16'(reg_r), 16'h0041);
    step();
    check("ws_idle", 16'(t_state), 16'(S_IDLE));

    // three back-to-back fetches with fetch_start held high
    set_r(8'h10);
    fetch_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bb_t1", 16'(t_state), 16'(S_T1));
      step();
      step();
      check("bb_t3_addr", rfsh_addr, {8'h12, 8'h10 + 8'(k)});
      step();
      check("bb_t4", 16'(t_state), 16'(S_T4));
      if (k == 2) fetch_start = 1'b0;
    end
    step();
    check("bb_idle", 16'(t_state), 16'(S_IDLE));
    check("bb_r_end", 16'(reg_r), 16'h0013);

    // LD R,A coinciding with T3 wins over the increment
    set_r(8'h20);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    step();
    ld_r = 1'b1;
    ld_r_data = 8'h55;
    #1;
    check("ld3_rwr", 16'(r_wr), 16'd1);
    check("ld3_rin", 16'(r_in), 16'h0055);
    check("ld3_addr", rfsh_addr, 16'h1220);
    step();
    ld_r = 1'b0;
    #1;
    check("ld3_r", 16'(reg_r), 16'h0055);
    check("ld3_t4_rwr", 16'(r_wr), 16'd0);
    step();

    // LD R,A in IDLE passes straight through
    ld_r = 1'b1;
    ld_r_data = 8'hA5;
    #1;
    check("ldi_state", 16'(t_state), 16'(S_IDLE));
    check("ldi_rwr", 16'(r_wr), 16'd1);
    check("ldi_rin", 16'(r_in), 16'h00A5);
    step();
    ld_r = 1'b0;
    #1;
    check("ldi_r", 16'(reg_r), 16'h00A5);

    // reset asserted in TW aborts the cycle with no increment
    set_r(8'h30);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    wait_n = 1'b0;
    step();
    step();
    check("rtw_tw", 16'(t_state), 16'(S_TW));
    reset = 1'b1;
    #1;
    check("rtw_state", 16'(t_state), 16'(S_IDLE));
    check("rtw_addr", rfsh_addr, 16'h0000);
    check("rtw_flags", {11'd0, m1_active, rfsh_active, opcode_latch, fetch_done, r_wr}, 16'h0000);
    step();
    check("rtw_r", 16'(reg_r), 16'h0030);
    reset = 1'b0;
    wait_n = 1'b1;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check("rtw_new_t1", 16'(t_state), 16'(S_T1));
    step();
    check("rtw_new_t2", 16'(t_state), 16'(S_T2));
    step();
    check("rtw_new_addr", rfsh_addr, 16'h1230);
    check("rtw_new_rin", 16'(r_in), 16'h0031);
    step();
    step();
    check("rtw_new_idle", 16'(t_state), 16'(S_IDLE));

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
